// File: rtl/control_identificador_bcd.sv
// control_identificador_bcd: round-robin identifier mux sequencer with double-dabble BCD conversion; BCD_SATURACION_EN clamps words above 999.
module control_identificador_bcd #(
  parameter int ANCHO   = 10,
  parameter int DIGITOS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_det,
  input  logic                   req_ref,
  input  logic [ANCHO-1:0]       dato_mux,
  output logic                   selc,
  output logic                   ack_det,
  output logic                   ack_ref,
  output logic                   ocupado,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   bcd_valido,
  output logic                   id_fuente,
  output logic                   sobre_rango
);
  localparam int BW = 4*DIGITOS;
  localparam int CW = $clog2(ANCHO);
  typedef enum logic [1:0] {REPOSO, CAPTURA, CONVIERTE, LISTO} estado_t;
`ifdef BCD_SATURACION_EN
  localparam logic [ANCHO-1:0] SAT = ANCHO'(10**(DIGITOS-1)-1);
`endif
  estado_t           estado_q, estado_d;
  logic              selc_q, selc_d, ptr_q, ptr_d;
  logic              ack_det_q, ack_det_d, ack_ref_q, ack_ref_d, ocupado_q;
  logic [ANCHO-1:0]  bin_q, bin_d;
  logic [BW-1:0]     acc_q, acc_d, adj, bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              valido_q, valido_d, id_q, id_d;
  logic [BW+ANCHO-1:0] sh;
  logic              gnt_det, gnt_ref, fin;
  // ptr_q high means the determined-value source wins a tie
  assign gnt_det = req_det & (~req_ref | ptr_q);
  assign gnt_ref = req_ref & ~gnt_det;
  assign fin = (estado_q == CONVIERTE) && (cnt_q == CW'(ANCHO-1));
  assign sh = {adj, bin_q} << 1;
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITOS; i++)
      if (acc_q[4*i+:4] >= 4'd5) adj[4*i+:4] = acc_q[4*i+:4] + 4'd3;
  end
  always_comb begin
    estado_d  = estado_q;
    selc_d    = selc_q;
    ptr_d     = ptr_q;
    ack_det_d = 1'b0;
    ack_ref_d = 1'b0;
    bin_d     = bin_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    valido_d  = 1'b0;
    id_d      = id_q;
    case (estado_q)
      REPOSO: if (gnt_det | gnt_ref) begin
        estado_d  = CAPTURA;
        selc_d    = gnt_det;
        ptr_d     = gnt_ref;
        ack_det_d = gnt_det;
        ack_ref_d = gnt_ref;
      end
      CAPTURA: begin
`ifdef BCD_SATURACION_EN
        bin_d = (dato_mux > SAT) ? SAT : dato_mux;
`else
        bin_d = dato_mux;
`endif
        acc_d    = '0;
        cnt_d    = '0;
        estado_d = CONVIERTE;
      end
      CONVIERTE: begin
        acc_d = sh[BW+ANCHO-1:ANCHO];
        bin_d = sh[ANCHO-1:0];
        cnt_d = cnt_q + 1'b1;
        if (fin) begin
          estado_d = LISTO;
          bcd_d    = sh[BW+ANCHO-1:ANCHO];
          valido_d = 1'b1;
          id_d     = selc_q;
        end
      end
      default: estado_d = REPOSO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= REPOSO;
      selc_q    <= 1'b0;
      ptr_q     <= 1'b1;
      ack_det_q <= 1'b0;
      ack_ref_q <= 1'b0;
      ocupado_q <= 1'b0;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      valido_q  <= 1'b0;
      id_q      <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      selc_q    <= selc_d;
      ptr_q     <= ptr_d;
      ack_det_q <= ack_det_d;
      ack_ref_q <= ack_ref_d;
      ocupado_q <= estado_d != REPOSO;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      valido_q  <= valido_d;
      id_q      <= id_d;
    end
  end
`ifdef BCD_SATURACION_EN
  logic ovr_q, sobre_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q   <= 1'b0;
      sobre_q <= 1'b0;
    end else begin
      if (estado_q == CAPTURA) ovr_q <= dato_mux > SAT;
      if (fin) sobre_q <= ovr_q;
    end
  end
  assign sobre_rango = sobre_q;
`else
  assign sobre_rango = 1'b0;
`endif
  assign selc       = selc_q;
  assign ack_det    = ack_det_q;
  assign ack_ref    = ack_ref_q;
  assign ocupado    = ocupado_q;
  assign bcd        = bcd_q;
  assign bcd_valido = valido_q;
  assign id_fuente  = id_q;
endmodule

// File: tb/tb_control_identificador_bcd.sv
// tb_control_identificador_bcd: directed and random requests checked against a decimal-digit model of the converter.
module tb_control_identificador_bcd;
  logic        clk = 1'b0;
  logic        reset, req_det, req_ref;
  logic [9:0]  det_val, ref_val, dato_mux;
  logic        selc, ack_det, ack_ref, ocupado, bcd_valido, id_fuente, sobre_rango;
  logic [15:0] bcd;
  int          errors = 0, checks = 0;
  control_identificador_bcd dut (
    .clk(clk), .reset(reset), .req_det(req_det), .req_ref(req_ref), .dato_mux(dato_mux),
    .selc(selc), .ack_det(ack_det), .ack_ref(ack_ref), .ocupado(ocupado), .bcd(bcd),
    .bcd_valido(bcd_valido), .id_fuente(id_fuente), .sobre_rango(sobre_rango)
  );
  always #5 clk = ~clk;
  // the external mux the select line drives
  assign dato_mux = selc ? det_val : ref_val;
  function automatic logic [15:0] modelo(input int v);
    int x = v;
    logic [15:0] r = '0;
`ifdef BCD_SATURACION_EN
    if (x > 999) x = 999;
`endif
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic logic sobre_modelo(input int v);
`ifdef BCD_SATURACION_EN
    return v > 999;
`else
    return v < 0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic chk_reposo(input string tag);
    chk({tag, "_selc"}, 32'(selc), 0);
    chk({tag, "_ack"}, 32'({ack_det, ack_ref}), 0);
    chk({tag, "_ocupado"}, 32'(ocupado), 0);
    chk({tag, "_bcd"}, 32'(bcd), 0);
    chk({tag, "_valido"}, 32'(bcd_valido), 0);
    chk({tag, "_id"}, 32'(id_fuente), 0);
    chk({tag, "_sobre"}, 32'(sobre_rango), 0);
  endtask
  task automatic wait_ack(input bit det);
    int n = 0;
    @(negedge clk); n++;
    while (!(ack_det | ack_ref) && n < 20) begin
      @(negedge clk); n++;
    end
    chk("ack_lat", n, 1);
    chk("ack_det", 32'(ack_det), 32'(det));
    chk("ack_ref", 32'(ack_ref), 32'(!det));
    chk("selc", 32'(selc), 32'(det));
    chk("ocupado_busy", 32'(ocupado), 1);
  endtask
  task automatic wait_done(input bit det, input int v, input int lat);
    int n = 0;
    @(negedge clk); n++;
    while (!bcd_valido && n < 20) begin
      @(negedge clk); n++;
    end
    chk("done_lat", n, 32'(lat));
    chk("bcd", 32'(bcd), 32'(modelo(v)));
    chk("id_fuente", 32'(id_fuente), 32'(det));
    chk("sobre_rango", 32'(sobre_rango), 32'(sobre_modelo(v)));
    @(negedge clk);
    chk("valido_pulse", 32'(bcd_valido), 0);
    chk("bcd_hold", 32'(bcd), 32'(modelo(v)));
    chk("ocupado_idle", 32'(ocupado), 0);
  endtask
  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask
  initial begin
    int v;
    bit s;
    reset = 1'b1; req_det = 1'b0; req_ref = 1'b0; det_val = '0; ref_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reposo("reset");
    // single determined-value request
    det_val = 10'd637; reset = 1'b0; req_det = 1'b1;
    wait_ack(1'b1);
    wait_done(1'b1, 637, 11);
    req_det = 1'b0;
    // both held: det, ref, det from a fresh pointer
    do_reset();
    det_val = 10'd5; ref_val = 10'd900; req_det = 1'b1; req_ref = 1'b1;
    wait_ack(1'b1); wait_done(1'b1, 5, 11);
    wait_ack(1'b0); wait_done(1'b0, 900, 11);
    wait_ack(1'b1); wait_done(1'b1, 5, 11);
    req_det = 1'b0; req_ref = 1'b0;
    // full-scale word
    det_val = 10'd1023; req_det = 1'b1;
    wait_ack(1'b1); wait_done(1'b1, 1023, 11);
    req_det = 1'b0;
    // zero from ref while det toggles mid-conversion
    ref_val = 10'd0; req_ref = 1'b1;
    wait_ack(1'b0);
    for (int i = 0; i < 3; i++) begin
      req_det = ~req_det;
      @(negedge clk);
      chk("toggle_selc", 32'(selc), 0);
      chk("toggle_ocupado", 32'(ocupado), 1);
    end
    req_det = 1'b0;
    wait_done(1'b0, 0, 8);
    req_ref = 1'b0;
    // reset in the middle of a conversion, request still held
    ref_val = 10'd321; req_ref = 1'b1;
    wait_ack(1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reposo("abort");
    reset = 1'b0;
    wait_ack(1'b0); wait_done(1'b0, 321, 11);
    req_ref = 1'b0;
    // random traffic
    for (int k = 0; k < 8; k++) begin
      s = 1'($urandom % 2);
      v = int'($urandom_range(0, 1023));
      if (s) det_val = 10'(v); else ref_val = 10'(v);
      req_det = s; req_ref = !s;
      wait_ack(s); wait_done(s, v, 11);
      req_det = 1'b0; req_ref = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_identificador_bcd.md
# control_identificador_bcd

Sequencer for the 10-bit identifier selection mux and the binary-to-BCD conversion path of the 7-segment controller. It arbitrates between two requesters: the determined value and the current reference. It drives the mux select and captures the selected 10-bit word. It then runs a 10-iteration shift-add-3 (double-dabble) conversion and presents four BCD digits with a one-cycle valid strobe to the display driver.

## Interface

Parameters:
- ANCHO, 10, width of the mux data word; the iteration count equals ANCHO.
- DIGITOS, 4, number of BCD digits produced; the `bcd` width is 4*DIGITOS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_det  input  1  request from the determined-value source; level, held until ack_det.
- req_ref  input  1  request from the current-reference source; level, held until ack_ref.
- dato_mux  input  ANCHO  mux output (identifier input word).
- selc  output  1  mux select; 1 = determined value, 0 = current reference; registered.
- ack_det  output  1  one-cycle pulse; determined-value word captured.
- ack_ref  output  1  one-cycle pulse; current-reference word captured.
- ocupado  output  1  high in every state except REPOSO.
- bcd  output  4*DIGITOS  converted digits; digit 0 in bits [3:0]; held until the next LISTO.
- bcd_valido  output  1  one-cycle strobe; `bcd` updated.
- id_fuente  output  1  source of the current `bcd` (1 = determined value); updated with `bcd`.
- sobre_rango  output  1  saturation flag (see Configuration); tied 0 when the macro is undefined.

## Operation

- States: REPOSO, CAPTURA, CONVIERTE, LISTO.
- REPOSO:
  - No request: stay in REPOSO.
  - One request: grant it.
  - Both requests: grant the source not served last (round-robin pointer).
  - On grant: register selc to the granted source, update the pointer, go to CAPTURA.
- CAPTURA:
  - The mux has had one full cycle with the new selc.
  - Latch dato_mux into the binary shift register and clear the BCD accumulator and iteration counter.
  - Pulse the matching ack for this cycle only.
  - Go to CONVIERTE.
- CONVIERTE, each cycle:
  - Add 3 to every accumulator digit >= 5.
  - Shift {accumulator, binary} left by one and increment the counter.
  - After ANCHO iterations (counter = ANCHO-1 in the current cycle), go to LISTO.
- LISTO:
  - Assert bcd_valido for one cycle; the bcd and id_fuente registers were loaded on entry.
  - Return to REPOSO.
- Requests sampled outside REPOSO are ignored; a requester still holding req is served on the next REPOSO visit.
- selc holds its value between grants; it changes only on a REPOSO grant.
- Arithmetic: the accumulator is 4*DIGITOS bits. 1023 converts to 0x1023 without overflow at the defaults.
- Reset values:
  - state = REPOSO
  - selc = 0, ocupado = 0
  - ack_det = ack_ref = 0
  - bcd = 0, bcd_valido = 0
  - id_fuente = 0, sobre_rango = 0
  - round-robin pointer favours req_det first
- Reset asserted mid-conversion aborts the conversion. bcd returns to 0, no ack or strobe is emitted afterwards, and the pending request is re-arbitrated after reset is released.

## Timing

- Request high before edge k, FSM in REPOSO: selc valid after k, ack pulse in cycle k+1, bcd/bcd_valido valid in cycle k+12.
- Throughput: one conversion per 13 cycles. A requester holding req through LISTO is re-granted at the REPOSO edge.
- dato_mux must be stable during the CAPTURA cycle. Source data changes after the ack are not observed.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- Macro: BCD_SATURACION_EN.
- Defined:
  - A captured word > 999 is replaced by 999 before conversion.
  - sobre_rango is set with bcd in LISTO and holds until the next LISTO.
  - The top digit is always 0 at DIGITOS = 4.
- Undefined:
  - Full-range conversion (0–1023 → 0x0000–0x1023).
  - sobre_rango is constant 0.

## Test plan

- Reset, then req_det=1 with dato_mux=10'd637 → selc=1 after the first edge, ack_det in the next cycle, bcd=16'h0637 with bcd_valido and id_fuente=1 twelve cycles after the grant.
- req_det and req_ref both held high, sources 10'd5 / 10'd900 → grants alternate det, ref, det. Outputs: bcd 0x0005 (id 1), then 0x0900 (id 0), each strobe exactly one cycle.
- dato_mux=10'd1023, macro undefined → bcd=16'h1023, sobre_rango=0. Macro defined → bcd=16'h0999, sobre_rango=1.
- dato_mux=0 from req_ref → bcd=0, bcd_valido pulse. Toggle req_det during CONVIERTE → no change to selc or state until REPOSO.
- Reset asserted at iteration 5 of a conversion → next-cycle state REPOSO with all outputs at reset values. The held request is re-served and completes with correct digits.
